// File: rtl/ex_alu_muldiv_pkg.sv
// Shared funct codes, bus widths and mul/div engine state encoding for the EX stage.
package ex_alu_muldiv_pkg;

    localparam int FUNCT_WIDTH    = 6;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int SHAMT_WIDTH    = 5;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL   = 6'h00;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL   = 6'h02;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA   = 6'h03;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MFHI  = 6'h10;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MFLO  = 6'h12;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADDU  = 6'h21;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUBU  = 6'h23;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND   = 6'h24;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR    = 6'h25;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_XOR   = 6'h26;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NOR   = 6'h27;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT   = 6'h2A;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

    function automatic logic is_muldiv(input logic [FUNCT_WIDTH-1:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/ex_alu_muldiv_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on unsigned magnitudes,
// with the sign fix-up applied combinationally while the engine sits in DONE.
module muldiv_iter
    import ex_alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    input  logic                  signed_op,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    md_state_e              state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]  q;
    logic [DATA_WIDTH-1:0]  b_mag;
    logic                   sign_a;
    logic                   sign_b;
    logic                   div_op;

    logic [DATA_WIDTH:0]     add_sum;
    logic [DATA_WIDTH:0]     shifted;
    logic [DATA_WIDTH:0]     diff;
    logic [2*DATA_WIDTH-1:0] product;

    function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // acc/q form one double-width shift register: mult shifts right, div shifts left.
    always_comb begin
        add_sum = {1'b0, acc} + (q[0] ? {1'b0, b_mag} : '0);
        shifted = {acc, q[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, b_mag};
        product = (sign_a ^ sign_b) ? -{acc, q} : {acc, q};
        if (div_op) begin
            // Divide by zero leaves q all ones; the remainder fix-up then restores operand_1.
            lo = cond_neg(q, (sign_a ^ sign_b) && (b_mag != '0));
            hi = cond_neg(acc, sign_a);
        end else begin
            hi = product[2*DATA_WIDTH-1:DATA_WIDTH];
            lo = product[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            b_mag  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div_op <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        sign_a <= signed_op & a[DATA_WIDTH-1];
                        sign_b <= signed_op & b[DATA_WIDTH-1];
                        acc    <= '0;
                        q      <= cond_neg(a, signed_op & a[DATA_WIDTH-1]);
                        b_mag  <= cond_neg(b, signed_op & b[DATA_WIDTH-1]);
                        div_op <= is_div;
                        cnt    <= '0;
                        state  <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (div_op) begin
                        acc <= diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
                        q   <= {q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
                    end else begin
                        acc <= add_sum[DATA_WIDTH:1];
                        q   <= {add_sum[0], q[DATA_WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!hold) begin
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/ex_alu_muldiv.sv
// EX-stage execute unit: combinational ALU/shifter, HI/LO registers, and the
// stall/write-enable qualification around the iterative mul/div engine.
module ex_alu_muldiv
    import ex_alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_current_stage,
    input  logic [FUNCT_WIDTH-1:0]    funct_in,
    input  logic [DATA_WIDTH-1:0]     operand_1_in,
    input  logic [DATA_WIDTH-1:0]     operand_2_in,
    input  logic [SHAMT_WIDTH-1:0]    shamt_in,
    input  logic                      write_reg_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic                      write_reg_en_out,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out,
    output logic                      stall_request,
    output logic [DATA_WIDTH-1:0]     hi_out,
    output logic [DATA_WIDTH-1:0]     lo_out
);

    logic signed [DATA_WIDTH-1:0] op1_s;
    logic signed [DATA_WIDTH-1:0] op2_s;
    logic [DATA_WIDTH-1:0]        hi_q;
    logic [DATA_WIDTH-1:0]        lo_q;
    logic [DATA_WIDTH-1:0]        md_hi;
    logic [DATA_WIDTH-1:0]        md_lo;
    logic                         md_busy;
    logic                         md_done;
    logic                         engine_idle;
    logic                         start;
    logic                         gpr_op;

    assign op1_s       = operand_1_in;
    assign op2_s       = operand_2_in;
    assign engine_idle = !md_busy && !md_done;
    // Gated by rst so a held mul/div funct cannot raise a stall while in reset.
    assign start       = rst && is_muldiv(funct_in) && engine_idle;

    assign stall_request      = md_busy || start;
    assign write_reg_en_out   = rst && write_reg_en_in && !stall_request && gpr_op;
    assign write_reg_addr_out = write_reg_addr_in;
    assign hi_out             = hi_q;
    assign lo_out             = lo_q;

    always_comb begin
        result_out = '0;
        gpr_op     = 1'b1;
        case (funct_in)
            FUNCT_ADDU: result_out = operand_1_in + operand_2_in;
            FUNCT_SUBU: result_out = operand_1_in - operand_2_in;
            FUNCT_AND:  result_out = operand_1_in & operand_2_in;
            FUNCT_OR:   result_out = operand_1_in | operand_2_in;
            FUNCT_XOR:  result_out = operand_1_in ^ operand_2_in;
            FUNCT_NOR:  result_out = ~(operand_1_in | operand_2_in);
            FUNCT_SLT:  result_out = {{(DATA_WIDTH-1){1'b0}}, (op1_s < op2_s)};
            FUNCT_SLTU: result_out = {{(DATA_WIDTH-1){1'b0}}, (operand_1_in < operand_2_in)};
            FUNCT_SLL:  result_out = operand_2_in << shamt_in;
            FUNCT_SRL:  result_out = operand_2_in >> shamt_in;
            FUNCT_SRA:  result_out = op2_s >>> shamt_in;
            FUNCT_MFHI: result_out = hi_q;
            FUNCT_MFLO: result_out = lo_q;
            default:    gpr_op     = 1'b0;
        endcase
    end

    // HI/LO update: engine results on DONE exit take priority over MTHI/MTLO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_done && !stall_current_stage) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
        end else if (engine_idle) begin
            if (funct_in == FUNCT_MTHI) hi_q <= operand_1_in;
            if (funct_in == FUNCT_MTLO) lo_q <= operand_1_in;
        end
    end

    muldiv_iter #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_muldiv_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hold     (stall_current_stage),
        .signed_op(~funct_in[0]),
        .is_div   (funct_in[1]),
        .a        (operand_1_in),
        .b        (operand_2_in),
        .busy     (md_busy),
        .done     (md_done),
        .hi       (md_hi),
        .lo       (md_lo)
    );

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Directed bench for ex_alu_muldiv: table of single-cycle ops, then mul/div sequences.
module tb_ex_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_current_stage;
    logic [5:0]  funct_in;
    logic [31:0] operand_1_in;
    logic [31:0] operand_2_in;
    logic [4:0]  shamt_in;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic [31:0] result_out;
    logic        write_reg_en_out;
    logic [4:0]  write_reg_addr_out;
    logic        stall_request;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_alu_muldiv dut (
        .clk                (clk),
        .rst                (rst),
        .stall_current_stage(stall_current_stage),
        .funct_in           (funct_in),
        .operand_1_in       (operand_1_in),
        .operand_2_in       (operand_2_in),
        .shamt_in           (shamt_in),
        .write_reg_en_in    (write_reg_en_in),
        .write_reg_addr_in  (write_reg_addr_in),
        .result_out         (result_out),
        .write_reg_en_out   (write_reg_en_out),
        .write_reg_addr_out (write_reg_addr_out),
        .stall_request      (stall_request),
        .hi_out             (hi_out),
        .lo_out             (lo_out)
    );

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  shamt;
        logic        wen;
        logic [31:0] res;
        logic        wen_exp;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic [5:0] next_f, input logic [31:0] exp_next);
        int n;
        @(posedge clk); #1;
        funct_in = f; operand_1_in = a; operand_2_in = b; write_reg_en_in = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall_request) break;
            n++;
            // Inputs wander while BUSY; the engine must use the latched operands.
            if (n > 1) begin
                operand_1_in = $urandom;
                operand_2_in = $urandom;
            end
        end
        chk("stall_cycles", 32'(n), 32'd33);
        chk("hi_before_write", hi_out, old_hi);
        chk("lo_before_write", lo_out, old_lo);
        if (hold > 0) begin
            stall_current_stage = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_hi", hi_out, old_hi);
                chk("hold_lo", lo_out, old_lo);
                chk("hold_stall", {31'd0, stall_request}, 32'd0);
            end
            stall_current_stage = 1'b0;
        end
        @(posedge clk); #1;
        funct_in = next_f; operand_1_in = '0; operand_2_in = '0; write_reg_en_in = 1'b1;
        @(negedge clk);
        chk("md_hi", hi_out, exp_hi);
        chk("md_lo", lo_out, exp_lo);
        chk("md_next_result", result_out, exp_next);
        chk("md_next_stall", {31'd0, stall_request}, 32'd0);
        chk("md_next_wen", {31'd0, write_reg_en_out}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{6'h21, 32'hFFFFFFFF, 32'h00000002, 5'd0,  1'b1, 32'h00000001, 1'b1};
        vecs[1]  = '{6'h23, 32'h00000000, 32'h00000001, 5'd0,  1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[2]  = '{6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b1, 32'hF000F000, 1'b1};
        vecs[3]  = '{6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b1, 32'hFFF0FFF0, 1'b1};
        vecs[4]  = '{6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b1, 32'h0FF00FF0, 1'b1};
        vecs[5]  = '{6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b1, 32'h000F000F, 1'b1};
        vecs[6]  = '{6'h2A, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b1, 32'h00000001, 1'b1};
        vecs[7]  = '{6'h2B, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b1, 32'h00000000, 1'b1};
        vecs[8]  = '{6'h00, 32'h00000000, 32'h00000001, 5'd31, 1'b1, 32'h80000000, 1'b1};
        vecs[9]  = '{6'h02, 32'h00000000, 32'h80000000, 5'd4,  1'b1, 32'h08000000, 1'b1};
        vecs[10] = '{6'h03, 32'h00000000, 32'h80000000, 5'd4,  1'b1, 32'hF8000000, 1'b1};
        vecs[11] = '{6'h11, 32'h12345678, 32'h00000000, 5'd0,  1'b1, 32'h00000000, 1'b0};
        vecs[12] = '{6'h13, 32'h9ABCDEF0, 32'h00000000, 5'd0,  1'b1, 32'h00000000, 1'b0};
        vecs[13] = '{6'h10, 32'h00000000, 32'h00000000, 5'd0,  1'b1, 32'h12345678, 1'b1};
        vecs[14] = '{6'h12, 32'h00000000, 32'h00000000, 5'd0,  1'b1, 32'h9ABCDEF0, 1'b1};
        vecs[15] = '{6'h3F, 32'h00000005, 32'h00000006, 5'd0,  1'b1, 32'h00000000, 1'b0};
        vecs[16] = '{6'h21, 32'h00000001, 32'h00000002, 5'd0,  1'b0, 32'h00000003, 1'b0};

        rst = 1'b0; stall_current_stage = 1'b0;
        funct_in = 6'h21; operand_1_in = 32'd0; operand_2_in = 32'd0; shamt_in = 5'd0;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd7;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall_request}, 32'd0);
        chk("rst_wen", {31'd0, write_reg_en_out}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("addr_pass", {27'd0, write_reg_addr_out}, 32'd7);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            funct_in = vecs[i].funct; operand_1_in = vecs[i].op1; operand_2_in = vecs[i].op2;
            shamt_in = vecs[i].shamt; write_reg_en_in = vecs[i].wen;
            @(negedge clk);
            chk($sformatf("vec%0d_result", i), result_out, vecs[i].res);
            chk($sformatf("vec%0d_wen", i), {31'd0, write_reg_en_out}, {31'd0, vecs[i].wen_exp});
            chk($sformatf("vec%0d_stall", i), {31'd0, stall_request}, 32'd0);
        end
        shamt_in = 5'd0;

        // MULT -2 x 3, then MFLO
        run_md(6'h18, 32'hFFFFFFFE, 32'h00000003, 0, 32'h12345678, 32'h9ABCDEF0,
               32'hFFFFFFFF, 32'hFFFFFFFA, 6'h12, 32'hFFFFFFFA);
        // DIV -7 / 2, then MFHI
        run_md(6'h1A, 32'hFFFFFFF9, 32'h00000002, 0, 32'hFFFFFFFF, 32'hFFFFFFFA,
               32'hFFFFFFFF, 32'hFFFFFFFD, 6'h10, 32'hFFFFFFFF);
        // DIV most-negative / -1 wraps
        run_md(6'h1A, 32'h80000000, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 32'hFFFFFFFD,
               32'h00000000, 32'h80000000, 6'h12, 32'h80000000);
        // DIVU 7 / 0
        run_md(6'h1B, 32'h00000007, 32'h00000000, 0, 32'h00000000, 32'h80000000,
               32'h00000007, 32'hFFFFFFFF, 6'h10, 32'h00000007);
        // MULTU 0x10000 x 0x10000 held 5 cycles in DONE
        run_md(6'h19, 32'h00010000, 32'h00010000, 5, 32'h00000007, 32'hFFFFFFFF,
               32'h00000001, 32'h00000000, 6'h10, 32'h00000001);

        // Reset asserted at BUSY cycle 10 of a DIVU
        @(posedge clk); #1;
        funct_in = 6'h1B; operand_1_in = 32'd100; operand_2_in = 32'd3; write_reg_en_in = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (stall_request) n++;
            if (n == 11) break;
        end
        chk("abort_reached_busy", 32'(n), 32'd11);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_stall", {31'd0, stall_request}, 32'd0);
        chk("abort_hi", hi_out, 32'd0);
        chk("abort_lo", lo_out, 32'd0);
        funct_in = 6'h21; operand_1_in = 32'd1; operand_2_in = 32'd2;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_stall", {31'd0, stall_request}, 32'd0);
        chk("post_abort_result", result_out, 32'd3);
        chk("post_abort_wen", {31'd0, write_reg_en_out}, 32'd1);
        @(posedge clk); #1;
        funct_in = 6'h13; operand_1_in = 32'd5;
        @(posedge clk); #1;
        funct_in = 6'h12; operand_1_in = 32'd0;
        @(negedge clk);
        chk("post_abort_mtlo_mflo", result_out, 32'd5);
        chk("post_abort_lo", lo_out, 32'd5);
        chk("post_abort_hi", hi_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_alu_muldiv.md
Name: ex_alu_muldiv

Overview:
- EX-stage execute unit; consumes the ID/EX pipeline register outputs: funct, operand_1, operand_2, shamt, write_reg_en, write_reg_addr.
- Single-cycle ALU/shift ops produce a combinational result toward the EX/MEM register.
- MULT/MULTU/DIV/DIVU run on an iterative 32-step engine with internal HI/LO registers.
- Raises stall_request to the pipeline controller, which holds ID/EX and earlier stages and bubbles EX/MEM while the engine is busy.

Parameters:
- DATA_WIDTH, 32, operand/result/HI/LO width; iteration count equals DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_current_stage  in  1  EX held by the controller.
- funct_in  in  6  SPECIAL funct code.
- operand_1_in  in  DATA_WIDTH  rs value.
- operand_2_in  in  DATA_WIDTH  rt value.
- shamt_in  in  5  shift amount.
- write_reg_en_in  in  1  GPR write enable from ID.
- write_reg_addr_in  in  5  GPR destination.
- result_out  out  DATA_WIDTH  EX result, combinational.
- write_reg_en_out  out  1  qualified GPR write enable.
- write_reg_addr_out  out  5  pass-through of write_reg_addr_in.
- stall_request  out  1  EX needs more cycles.
- hi_out  out  DATA_WIDTH  HI register, for debug and MFHI.
- lo_out  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, counter=0, hi=lo=0, stall_request=0, write_reg_en_out=0. The datapath registers are cleared.
- Single-cycle ops, combinational, no state:
  - ADDU 0x21 / SUBU 0x23: mod 2^32, no overflow trap.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLT 0x2A (signed), SLTU 0x2B (unsigned): result 0 or 1.
  - SLL 0x00, SRL 0x02, SRA 0x03: shift operand_2 by shamt_in.
  - MFHI 0x10 / MFLO 0x12: result = hi / lo.
  - Any other funct: result=0, write_reg_en_out=0.
- MTHI 0x11 / MTLO 0x13: hi/lo <= operand_1 at each rising edge while present in IDLE; repeated writes under stall are harmless. result=0, write_reg_en_out=0.
- write_reg_en_out = write_reg_en_in AND NOT stall_request AND funct is a GPR-writing op.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if funct ∈ {MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B}:
    - stall_request=1 in the same cycle (combinational).
    - At the edge: latch operand magnitudes and sign flags; signed ops use absolute values.
    - counter=0; go to BUSY.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; counter+1.
    - After step DATA_WIDTH-1, go to DONE.
    - stall_request=1.
    - stall_current_stage is ignored; iteration continues.
  - DONE: apply sign fix-up.
    - mult: 64-bit product negated if signs differ; {hi,lo} = product.
    - div: lo = quotient, negated if signs differ; hi = remainder, sign of dividend.
    - stall_request=0.
    - If stall_current_stage=0: write hi/lo at the edge and go to IDLE.
    - Otherwise stay in DONE, with no write and no restart.
- Latency: a mul/div occupies EX for DATA_WIDTH+2 cycles (1 IDLE-start + 32 BUSY + 1 DONE). The next instruction enters EX the edge after DONE exits.
- Back-to-back: MFHI immediately after MULT reads the updated hi, because the write occurs on the edge it enters EX.
- Divide by zero (operand_2=0): no trap. lo=0xFFFFFFFF, hi=operand_1 (unsigned semantics), sign fix-up skipped. Still takes full latency.
- Signed most-negative cases: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, by natural wrap.
- Reset mid-BUSY: aborts immediately; hi/lo=0, IDLE. No partial write.
- Operands are latched at start; changes on the inputs during BUSY have no effect.

Decomposition:
- Funct code constants and the DATA/REG_ADDR/SHAMT bus widths go in the shared global define file, alongside the existing bus macros.
- One sub-module, muldiv_iter:
  - Inputs: start, signed_op, is_div, a, b.
  - Outputs: busy, done, hi, lo.
  - Contains the FSM, counter and sign fix-up.
- ex_alu_muldiv holds the combinational ALU, HI/LO registers, and enable/stall qualification.

Test Plan:
- ADDU 0xFFFFFFFF + 0x2 → result 0x1, write_reg_en_out=1, stall_request=0.
- SRA shamt=4, operand_2=0x80000000 → 0xF8000000; SLT -1 vs 1 → 1; SLTU same operands → 0.
- MULT 0xFFFFFFFE × 0x3:
  - stall_request high for exactly 33 cycles.
  - Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA; following MFLO → 0xFFFFFFFA.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 → lo=0xFFFFFFFF, hi=0x7.
- MULTU 0x10000 × 0x10000 with stall_current_stage held high 5 cycles in DONE → hi/lo unchanged until release, then hi=0x1, lo=0x0; exactly one write.
- Assert rst low at BUSY cycle 10 of DIVU → stall_request=0 and hi=lo=0 immediately; FSM in IDLE after release.
